// File: rtl/timer_dev.sv
// timer_dev: memory-mapped down-counting timer with one-shot / auto-reload modes and an interrupt flag.
//
// Ports:
//   clk    - single clock, all registers update on its rising edge
//   reset  - asynchronous, active-low reset
//   addr   - CPU byte address; only addr[3:2] is decoded
//   we     - write strobe
//   wdata  - store data
//   rdata  - load data, combinational from addr and current register values
//   irq    - interrupt request (IM & int_flag, or int_flag alone without the mask feature)
//
// Register map (addr[3:2]): 0 CTRL {IM,MODE[1:0],EN}, 1 PRESET, 2 COUNT (read-only), 3 reads 0.
//
// Configuration: define TIMER_IRQ_MASK_EN to implement CTRL.IM (bit3) as an irq mask.
// Without it, bit3 is not stored, reads 0, and irq is the raw int_flag.
module timer_dev (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_CNT  = 2'd2;
    localparam logic [1:0] S_INT  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        en_q, en_d;
    logic [1:0]  mode_q, mode_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        int_flag_q, int_flag_d;
    logic        im;
    logic        wr_ctrl, wr_preset;
    logic        unused_addr_bits;

    assign wr_ctrl          = we && (addr[3:2] == 2'd0);
    assign wr_preset        = we && (addr[3:2] == 2'd1);
    assign unused_addr_bits = &{1'b0, addr[31:4], addr[1:0]};

`ifdef TIMER_IRQ_MASK_EN
    logic im_q, im_d;

    assign im_d = wr_ctrl ? wdata[3] : im_q;
    assign im   = im_q;
    assign irq  = im_q & int_flag_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) im_q <= 1'b0;
        else        im_q <= im_d;
    end
`else
    assign im  = 1'b0;
    assign irq = int_flag_q;
`endif

    always_comb begin
        state_d    = state_q;
        en_d       = en_q;
        mode_d     = mode_q;
        preset_d   = preset_q;
        count_d    = count_q;
        int_flag_d = int_flag_q;
        case (state_q)
            S_IDLE: if (en_q) state_d = S_LOAD;
            S_LOAD: begin
                count_d = preset_q;
                state_d = S_CNT;
            end
            S_CNT: begin
                if (!en_q) begin
                    state_d = S_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    // PRESET of 0 or 1 both expire here, so both give the same latency
                    count_d    = 32'd0;
                    int_flag_d = 1'b1;
                    state_d    = S_INT;
                end
            end
            default: begin
                // MODE 2 and 3 behave as one-shot
                if (mode_q == 2'd1) begin
                    int_flag_d = 1'b0;
                    state_d    = S_LOAD;
                end else begin
                    en_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
        endcase
        // A CTRL write overrides the FSM's own EN clear and always drops the flag
        if (wr_ctrl) begin
            en_d       = wdata[0];
            mode_d     = wdata[2:1];
            int_flag_d = 1'b0;
        end
        if (wr_preset) preset_d = wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            en_q       <= 1'b0;
            mode_q     <= 2'd0;
            preset_q   <= 32'd0;
            count_q    <= 32'd0;
            int_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            mode_q     <= mode_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            int_flag_q <= int_flag_d;
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (addr[3:2])
            2'd0:    rdata = {28'd0, im, mode_q, en_q};
            2'd1:    rdata = preset_q;
            2'd2:    rdata = count_q;
            default: rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_timer_dev.sv
// tb_timer_dev: directed self-checking bench for timer_dev.
module tb_timer_dev;

    localparam bit HAS_IM =
`ifdef TIMER_IRQ_MASK_EN
        1'b1;
`else
        1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = 32'd0;
    logic        we = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    timer_dev dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick(1);
    endtask

    logic [31:0] count_tbl [12] = '{0, 3, 2, 1, 0, 0, 3, 2, 1, 0, 0, 3};
    logic        irq_tbl   [12] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk_rd("rst_ctrl", 32'h0, 32'd0);
        chk_rd("rst_preset", 32'h4, 32'd0);
        chk_rd("rst_count", 32'h8, 32'd0);
        reset = 1'b1;
        tick(1);

        // one-shot, PRESET=5: irq rises 7 edges after the enabling write
        wr(32'h4, 32'd5);
        wr(32'h0, 32'h9);
        tick(6);
        chk("os_irq_early", {31'd0, irq}, 32'd0);
        tick(1);
        chk("os_irq_rise", {31'd0, irq}, 32'd1);
        chk_rd("os_count0", 32'h8, 32'd0);
        tick(1);
        chk("os_state_idle", {30'd0, dut.state_q}, 32'd0);
        chk_rd("os_en_cleared", 32'h0, HAS_IM ? 32'h8 : 32'h0);
        tick(3);
        chk("os_irq_held", {31'd0, irq}, 32'd1);

        // PRESET=0 behaves like PRESET=1; CTRL write clears the held flag
        wr(32'h4, 32'd0);
        wr(32'h0, 32'h9);
        chk("p0_flag_cleared", {31'd0, irq}, 32'd0);
        tick(2);
        chk_rd("p0_count", 32'h8, 32'd0);
        chk("p0_irq_early", {31'd0, irq}, 32'd0);
        tick(1);
        chk("p0_irq_rise", {31'd0, irq}, 32'd1);

        // auto-reload, PRESET=3: 5-cycle period, one-cycle pulses
        do_reset();
        wr(32'h4, 32'd3);
        wr(32'h0, 32'hB);
        for (int i = 0; i < 12; i++) begin
            tick(1);
            chk($sformatf("ar_irq_%0d", i + 1), {31'd0, irq}, {31'd0, irq_tbl[i]});
            chk_rd($sformatf("ar_count_%0d", i + 1), 32'h8, count_tbl[i]);
        end

        // PRESET write mid-count only applies at the next LOAD
        wr(32'h4, 32'd1);
        chk_rd("pw_count_unaffected", 32'h8, 32'd2);
        tick(2);
        chk("pw_irq_old_period", {31'd0, irq}, 32'd1);
        tick(2);
        chk_rd("pw_new_count", 32'h8, 32'd1);
        chk("pw_irq_low", {31'd0, irq}, 32'd0);
        tick(1);
        chk("pw_irq_new_period", {31'd0, irq}, 32'd1);

        // CTRL write coinciding with the one-shot EN clear: bus wins
        do_reset();
        wr(32'h4, 32'd1);
        wr(32'h0, 32'h9);
        tick(3);
        chk("col_irq", {31'd0, irq}, 32'd1);
        wr(32'h0, 32'h9);
        chk("col_flag_cleared", {31'd0, irq}, 32'd0);
        chk_rd("col_ctrl", 32'h0, HAS_IM ? 32'h9 : 32'h1);
        tick(3);
        chk("col_restart_irq", {31'd0, irq}, 32'd1);

        // stop mid-count
        do_reset();
        wr(32'h4, 32'd10);
        wr(32'h0, 32'h1);
        tick(6);
        chk_rd("stop_count6", 32'h8, 32'd6);
        wr(32'h0, 32'h8);
        tick(3);
        chk_rd("stop_count_held", 32'h8, 32'd5);
        chk("stop_no_irq", {31'd0, irq}, 32'd0);
        chk("stop_state_idle", {30'd0, dut.state_q}, 32'd0);
        chk_rd("stop_ctrl", 32'h0, HAS_IM ? 32'h8 : 32'h0);

        // mask: IM=0 keeps irq low while the flag is set (only with the mask feature)
        do_reset();
        wr(32'h4, 32'd2);
        wr(32'h0, 32'h1);
        tick(4);
        chk("mask_flag_set", {31'd0, dut.int_flag_q}, 32'd1);
        chk("mask_irq", {31'd0, irq}, HAS_IM ? 32'd0 : 32'd1);
        wr(32'h0, 32'h8);
        chk("mask_flag_cleared", {31'd0, dut.int_flag_q}, 32'd0);
        chk("mask_irq_after", {31'd0, irq}, 32'd0);

        // reset mid-count
        do_reset();
        wr(32'h4, 32'd10);
        wr(32'h0, 32'h1);
        tick(8);
        chk_rd("rmc_count4", 32'h8, 32'd4);
        reset = 1'b0;
        #1;
        chk("rmc_irq", {31'd0, irq}, 32'd0);
        chk_rd("rmc_count", 32'h8, 32'd0);
        chk_rd("rmc_ctrl", 32'h0, 32'd0);
        @(negedge clk);
        chk_rd("rmc_preset", 32'h4, 32'd0);
        reset = 1'b1;
        tick(5);
        chk_rd("rmc_no_count", 32'h8, 32'd0);
        chk("rmc_state_idle", {30'd0, dut.state_q}, 32'd0);

        // address edges
        do_reset();
        wr(32'h4, 32'd7);
        wr(32'hC, 32'hFFFF);
        wr(32'h8, 32'h1234);
        chk_rd("addr_preset", 32'h4, 32'd7);
        chk_rd("addr_ctrl", 32'h0, 32'd0);
        chk_rd("addr_count", 32'h8, 32'd0);
        chk_rd("addr_c_reads0", 32'hC, 32'd0);
        wr(32'h0, 32'hFFFF_FFFF);
        chk_rd("addr_ctrl_mask", 32'h0, HAS_IM ? 32'hF : 32'h7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
